// File: rtl/jk_excite_counter.sv
// Modulo-MOD up/down counter built on a bank of JK flip-flops.
// The next state is chosen first, then converted into per-bit J/K excitation.
// The bank changes only through those J/K pairs, including on reset.
// The applied J/K vectors are registered and exported for bit-by-bit checking.
module jk_excite_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             TC,
    output logic             CHG
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    // One extra bit so that MOD == 2^WIDTH still compares correctly against D.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic             chg_q;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;

    // Next-state selection in priority order: reset, load (clamped), count, hold.
    always_comb begin
        next_state = q_q;
        if (RESET) begin
            next_state = '0;
        end else if (LOAD) begin
            next_state = ({1'b0, D} < MOD_EXT) ? D : MAX_VAL;
        end else if (EN && UP) begin
            next_state = (q_q == MAX_VAL) ? '0 : q_q + 1'b1;
        end else if (EN) begin
            next_state = (q_q == '0) ? MAX_VAL : q_q - 1'b1;
        end
    end

    // Inverse JK mapping with all don't-cares resolved to 0, so J=K=1 never occurs.
    always_comb begin
        j_d = ~q_q & next_state;
        k_d = q_q & ~next_state;
    end

    // Each bank bit is a JK flip-flop: J sets, K clears, neither holds.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        always_ff @(posedge CLK) begin
            if (j_d[i]) begin
                q_q[i] <= 1'b1;
            end else if (k_d[i]) begin
                q_q[i] <= 1'b0;
            end
        end
    end

    // Record the excitation applied on this edge and whether the state moved.
    always_ff @(posedge CLK) begin
        j_q   <= j_d;
        k_q   <= k_d;
        chg_q <= (next_state != q_q);
    end

    // Excitation must never request a toggle.
    always_comb begin
        assert ((j_d & k_d) == '0)
        else $error("jk_excite_counter: J and K both asserted on a bit");
    end

    assign Q   = q_q;
    assign J   = j_q;
    assign K   = k_q;
    assign CHG = chg_q;
    // Terminal count looks ahead to the wrap in the current direction.
    assign TC  = EN & (UP ? (q_q == MAX_VAL) : (q_q == '0));

endmodule

// File: tb/tb_jk_excite_counter.sv
// Directed-vector and random-soak bench for jk_excite_counter (WIDTH=4, MOD=10).
module tb_jk_excite_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             reset, en, up, load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q, j, k;
    logic             tc, chg;

    int n_cmp = 0;
    int n_err = 0;

    jk_excite_counter #(
        .WIDTH(WIDTH),
        .MOD  (MOD)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .EN   (en),
        .UP   (up),
        .LOAD (load),
        .D    (d),
        .Q    (q),
        .J    (j),
        .K    (k),
        .TC   (tc),
        .CHG  (chg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] d;
        logic       tc;   // TC expected before the edge, with these inputs applied
        logic [3:0] q;    // expected after the edge
        logic [3:0] j;
        logic [3:0] k;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ld, input logic en_v, input logic up_v,
                       input logic [3:0] d_v, input logic tc_v, input logic [3:0] q_v,
                       input logic [3:0] j_v, input logic [3:0] k_v, input logic chg_v);
        vec_t v;
        v = '{rst: rst, ld: ld, en: en_v, up: up_v, d: d_v, tc: tc_v,
              q: q_v, j: j_v, k: k_v, chg: chg_v};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic rst,
                                              input logic ld, input logic en_v,
                                              input logic up_v, input logic [3:0] d_v);
        if (rst) return 4'd0;
        if (ld) return (int'(d_v) < MOD) ? d_v : 4'(MOD - 1);
        if (en_v && up_v) return (int'(cur) == MOD - 1) ? 4'd0 : cur + 4'd1;
        if (en_v) return (cur == 4'd0) ? 4'(MOD - 1) : cur - 4'd1;
        return cur;
    endfunction

    task automatic drive(input logic rst, input logic ld, input logic en_v, input logic up_v,
                         input logic [3:0] d_v);
        @(negedge clk);
        reset = rst;
        load  = ld;
        en    = en_v;
        up    = up_v;
        d     = d_v;
        #1;
    endtask

    logic [3:0] ref_q;
    logic [3:0] prev_q;
    logic [3:0] exp_q;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        en    = 1'b0;
        up    = 1'b0;
        d     = '0;

        // Power-up: two reset edges leave a known zero state with idle excitation.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        check("reset_q", -1, q, 0);
        check("reset_j", -1, j, 0);
        check("reset_k", -1, k, 0);
        check("reset_chg", -1, chg, 0);
        check("reset_tc", -1, tc, 0);

        //   rst ld en up d       tc   q      j        k        chg
        add(0, 1, 0, 0, 4'd7,  0, 4'd7, 4'b0111, 4'b0000, 1);
        add(1, 0, 0, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0111, 1);
        add(1, 0, 0, 0, 4'd0,  0, 4'd0, 4'b0000, 4'b0000, 0);
        // Up count 0..9 and wrap
        add(0, 0, 1, 1, 4'd0,  0, 4'd1, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd2, 4'b0010, 4'b0001, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd3, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd4, 4'b0100, 4'b0011, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd5, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd6, 4'b0010, 4'b0001, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd7, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd8, 4'b1000, 4'b0111, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd9, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  1, 4'd0, 4'b0000, 4'b1001, 1);
        // Down count with wrap
        add(0, 0, 1, 0, 4'd0,  1, 4'd9, 4'b1001, 4'b0000, 1);
        add(0, 0, 1, 0, 4'd0,  0, 4'd8, 4'b0000, 4'b0001, 1);
        add(0, 0, 1, 0, 4'd0,  0, 4'd7, 4'b0111, 4'b1000, 1);
        // Load, clamp, load beats count
        add(0, 1, 0, 0, 4'd5,  0, 4'd5, 4'b0000, 4'b0010, 1);
        add(0, 1, 0, 0, 4'd13, 0, 4'd9, 4'b1000, 4'b0100, 1);
        add(0, 1, 1, 1, 4'd5,  1, 4'd5, 4'b0100, 4'b1000, 1);
        // Hold at 6
        add(0, 1, 0, 0, 4'd6,  0, 4'd6, 4'b0010, 4'b0001, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 4'd0, 0, 4'd6, 4'b0000, 4'b0000, 0);
        // Reset wins over load and count
        add(1, 1, 1, 1, 4'd3,  0, 4'd0, 4'b0000, 4'b0110, 1);
        add(0, 1, 0, 0, 4'd15, 0, 4'd9, 4'b1001, 4'b0000, 1);
        // Direction change mid-count, both wraps, clamp of D == MOD
        add(0, 0, 1, 0, 4'd0,  0, 4'd8, 4'b0000, 4'b0001, 1);
        add(0, 0, 1, 1, 4'd0,  0, 4'd9, 4'b0001, 4'b0000, 1);
        add(0, 0, 1, 1, 4'd0,  1, 4'd0, 4'b0000, 4'b1001, 1);
        add(0, 0, 1, 0, 4'd0,  1, 4'd9, 4'b1001, 4'b0000, 1);
        add(0, 1, 0, 0, 4'd10, 0, 4'd9, 4'b0000, 4'b0000, 0);
        add(0, 0, 0, 0, 4'd0,  0, 4'd9, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].d);
            check("vec_tc", i, tc, vecs[i].tc);
            @(posedge clk);
            #1;
            check("vec_q", i, q, vecs[i].q);
            check("vec_j", i, j, vecs[i].j);
            check("vec_k", i, k, vecs[i].k);
            check("vec_chg", i, chg, vecs[i].chg);
        end

        // Random soak against the reference next-state model.
        ref_q = vecs[vecs.size() - 1].q;
        for (int c = 0; c < 10000; c++) begin
            logic r_rst, r_ld, r_en, r_up;
            logic [3:0] r_d;
            r_rst = ($urandom_range(0, 31) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = 1'($urandom_range(0, 1));
            r_d   = 4'($urandom_range(0, 15));
            drive(r_rst, r_ld, r_en, r_up, r_d);
            check("soak_tc", c, tc,
                  r_en & (r_up ? (int'(ref_q) == MOD - 1) : (ref_q == 4'd0)));
            prev_q = ref_q;
            exp_q  = model_next(ref_q, r_rst, r_ld, r_en, r_up, r_d);
            @(posedge clk);
            #1;
            check("soak_q", c, q, exp_q);
            check("soak_j", c, j, ~prev_q & exp_q);
            check("soak_k", c, k, prev_q & ~exp_q);
            check("soak_chg", c, chg, exp_q != prev_q);
            check("soak_jk_disjoint", c, j & k, 0);
            check("soak_q_range", c, int'(q) < MOD, 1);
            check("soak_jk_rebuild", c, j | (prev_q & ~k), q);
            ref_q = exp_q;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
